light_safety_monitor: RTL and testbench
=======================================

# light_safety_monitor

Lamp-side stage that sits directly downstream of the two-road traffic light controller. It registers the controller's road A/B light codes and passes them to the lamp outputs while checking every cycle for malformed codes, conflicting greens and illegal sequences. On any violation it latches a fault and forces both roads to flashing red until an explicit clear. A night-mode input overrides normal operation with flashing yellow on both roads.

## Interface
- BLINK_HALF, default 2: cycles per flash half-period (on, then off); legal range ≥ 1.
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- modo  in  1  1 = night mode (flashing yellow); ignored in FAULT
- a_in  in  3  road A code from controller
- b_in  in  3  road B code from controller
- fault_clr  in  1  level, sampled each edge; request to leave FAULT
- lamp_a  out  3  road A lamp drive
- lamp_b  out  3  road B lamp drive
- fault  out  1  1 while in FAULT
- fault_code  out  2  0 none, 1 not one-hot, 2 conflict, 3 illegal transition

## Operation
- Codes: RED 3'b100, YEL 3'b010, GRN 3'b001, OFF 3'b000.
- Reset values: lamp_a = lamp_b = RED, fault = 0, fault_code = 0, prev_a = prev_b = RED, state PASS, blink counter 0, phase 1.
- Checks are evaluated on the sampled a_in/b_in against prev_a/prev_b, with priority 1 > 2 > 3:
  - 1: a_in or b_in is not exactly one-hot.
  - 2: neither a_in nor b_in is RED.
  - 3: either road changes other than by hold, RED→GRN, GRN→YEL or YEL→RED.
- PASS:
  - No violation: lamps ← inputs, prev ← inputs.
  - Violation: go to FAULT, latch fault_code, set fault = 1, restart blink. Fault has priority over modo in the same cycle.
  - modo = 1 with no violation: go to NIGHT and restart blink.
- NIGHT:
  - Both lamps show YEL on phase 1 and OFF on phase 0.
  - All checks are suspended.
  - modo = 0: go to PASS, lamps ← inputs, prev ← inputs. No transition check on this edge; one-hot and conflict checks apply and can send the block directly to FAULT.
- FAULT:
  - Both lamps show RED on phase 1 and OFF on phase 0.
  - fault_code holds. modo is ignored.
  - fault_clr = 1 and inputs equal (GRN, RED): go to PASS, fault ← 0, fault_code ← 0, lamps ← inputs, prev ← inputs.
  - fault_clr with any other inputs is ignored.
- Blink restart (on entry to NIGHT or FAULT):
  - counter ← 0 and phase ← 1.
  - Lamps show the ON value on the entry edge itself.
- Blink run (every later edge in NIGHT or FAULT):
  - If counter == BLINK_HALF−1: counter ← 0, phase toggles.
  - Otherwise: counter increments.
  - The lamp output follows the new phase on the same edge.

## Timing
- Latency is one cycle: an input sampled at edge k appears on the lamps after edge k. All outputs are registered.
- Fault detection happens at the sampling edge. fault and the RED flash are visible after that same edge.
- Flash: the ON value lasts BLINK_HALF cycles, then OFF lasts BLINK_HALF cycles, repeating. With BLINK_HALF = 1 the lamps toggle every cycle.
- Counter width is max(1, $clog2(BLINK_HALF)). It wraps only through the compare, never by overflow.
- Reset asserted mid-flash or mid-fault: all outputs return to their reset values immediately (asynchronous). The first edge after release evaluates normally against prev = RED/RED.

## Structure
- Package light_pkg holds:
  - the RED/YEL/GRN/OFF localparams;
  - the state enum (PASS, NIGHT, FAULT);
  - the fault code enum (NONE, NOT_ONEHOT, CONFLICT, ILLEGAL_SEQ).
- The controller reuses the light code constants from light_pkg.
- Sub-module blink_gen (parameter BLINK_HALF; inputs clk, reset, restart, run; output phase) holds the counter and phase.
- The checks are combinational functions inside light_safety_monitor.

## Test plan
All scenarios use BLINK_HALF = 2.
- Reset, then apply the normal sequence (GRN,RED)×4, (YEL,RED), (RED,GRN)×3, (RED,YEL), repeated twice → lamps equal the inputs one cycle later, fault stays 0.
- From (GRN,RED), drive (GRN,GRN) → fault = 1, code = 2. Lamps show 100/100 for 2 cycles, then 000/000 for 2 cycles, alternating.
- From (GRN,RED), drive (RED,RED) → code = 3. Drive (3'b011, GRN) → code = 1 (priority over conflict).
- modo = 1 in PASS → lamps 010/010 ×2 cycles, then 000/000 ×2 cycles. modo = 0 with inputs (RED,GRN) → lamps 100/001 next cycle, no fault. Fault and modo = 1 on the same edge → FAULT.
- In FAULT:
  - fault_clr = 1 with inputs (RED,GRN) → stays in FAULT.
  - fault_clr = 1 with inputs (GRN,RED) → fault = 0, code = 0, lamps 001/100 next cycle.
  - Assert reset mid-flash → lamps 100/100 and fault 0 immediately.

Source files
------------

// File: rtl/light_pkg.sv
// Shared lamp codes and state/fault encodings for the traffic light controller
// and its downstream safety monitor.
package light_pkg;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   typedef enum logic [1:0] {PASS, NIGHT, FAULT} state_t;

   typedef enum logic [1:0] {
      NONE        = 2'd0,
      NOT_ONEHOT  = 2'd1,
      CONFLICT    = 2'd2,
      ILLEGAL_SEQ = 2'd3
   } fault_t;

endpackage

// File: rtl/blink_gen.sv
// Flash timebase: phase is ON for BLINK_HALF cycles, then OFF for BLINK_HALF cycles.
// A restart forces the ON half so the entry edge already shows the lit value.
module blink_gen #(
   parameter int BLINK_HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic run,
   output logic phase
);

   localparam int            CW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (restart) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (run) begin
         if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/light_safety_monitor.sv
// Registers the controller's light codes onto the lamps, latching a flashing-red
// fault on malformed codes, conflicting greens or illegal sequences.
module light_safety_monitor
   import light_pkg::*;
#(
   parameter int BLINK_HALF = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       modo,
   input  logic [2:0] a_in,
   input  logic [2:0] b_in,
   input  logic       fault_clr,
   output logic [2:0] lamp_a,
   output logic [2:0] lamp_b,
   output logic       fault,
   output logic [1:0] fault_code
);

   state_t     state, state_n;
   fault_t     code_q, code_n, viol;
   logic [2:0] prev_a, prev_b, prev_a_n, prev_b_n;
   logic       restart, run, phase;
   logic [2:0] on_code;

   function automatic logic onehot(input logic [2:0] c);
      return (c == RED) || (c == YEL) || (c == GRN);
   endfunction

   function automatic logic legal_step(input logic [2:0] p, input logic [2:0] n);
      return (n == p) || (p == RED && n == GRN) || (p == GRN && n == YEL) ||
             (p == YEL && n == RED);
   endfunction

   function automatic fault_t check(input logic [2:0] a, input logic [2:0] b,
                                    input logic [2:0] pa, input logic [2:0] pb,
                                    input logic seq);
      if (!onehot(a) || !onehot(b))                              return NOT_ONEHOT;
      if (a != RED && b != RED)                                  return CONFLICT;
      if (seq && !(legal_step(pa, a) && legal_step(pb, b)))      return ILLEGAL_SEQ;
      return NONE;
   endfunction

   // Leaving NIGHT has no trustworthy history, so the sequence check applies only in PASS.
   assign viol = check(a_in, b_in, prev_a, prev_b, state == PASS);

   always_comb begin
      state_n  = state;
      code_n   = code_q;
      prev_a_n = prev_a;
      prev_b_n = prev_b;
      restart  = 1'b0;
      run      = 1'b0;
      case (state)
         PASS: begin
            if (viol != NONE) begin
               state_n = FAULT;
               code_n  = viol;
               restart = 1'b1;
            end else if (modo) begin
               state_n = NIGHT;
               restart = 1'b1;
            end else begin
               prev_a_n = a_in;
               prev_b_n = b_in;
            end
         end
         NIGHT: begin
            if (!modo) begin
               if (viol != NONE) begin
                  state_n = FAULT;
                  code_n  = viol;
                  restart = 1'b1;
               end else begin
                  state_n  = PASS;
                  prev_a_n = a_in;
                  prev_b_n = b_in;
               end
            end else begin
               run = 1'b1;
            end
         end
         FAULT: begin
            if (fault_clr && a_in == GRN && b_in == RED) begin
               state_n  = PASS;
               code_n   = NONE;
               prev_a_n = a_in;
               prev_b_n = b_in;
            end else begin
               run = 1'b1;
            end
         end
         default: state_n = PASS;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= PASS;
         code_q <= NONE;
         prev_a <= RED;
         prev_b <= RED;
      end else begin
         state  <= state_n;
         code_q <= code_n;
         prev_a <= prev_a_n;
         prev_b <= prev_b_n;
      end
   end

   blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
      .clk    (clk),
      .reset  (reset),
      .restart(restart),
      .run    (run),
      .phase  (phase)
   );

   // In PASS the last accepted codes are exactly what the lamps must show.
   assign on_code    = (state == FAULT) ? RED : YEL;
   assign lamp_a     = (state == PASS) ? prev_a : (phase ? on_code : OFF);
   assign lamp_b     = (state == PASS) ? prev_b : (phase ? on_code : OFF);
   assign fault      = (state == FAULT);
   assign fault_code = code_q;

endmodule

// File: tb/tb_light_safety_monitor.sv
// Directed scoreboard bench for light_safety_monitor with BLINK_HALF = 2.
module tb_light_safety_monitor;
   import light_pkg::*;

   logic       clk, reset, modo, fault_clr;
   logic [2:0] a_in, b_in, lamp_a, lamp_b;
   logic       fault;
   logic [1:0] fault_code;

   typedef struct {
      logic [2:0] la;
      logic [2:0] lb;
      logic       f;
      logic [1:0] c;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   light_safety_monitor #(.BLINK_HALF(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .modo      (modo),
      .a_in      (a_in),
      .b_in      (b_in),
      .fault_clr (fault_clr),
      .lamp_a    (lamp_a),
      .lamp_b    (lamp_b),
      .fault     (fault),
      .fault_code(fault_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push(input logic [2:0] la, input logic [2:0] lb, input logic f,
                       input logic [1:0] c, input string nm);
      exp_t e;
      e.la = la; e.lb = lb; e.f = f; e.c = c; e.nm = nm;
      q.push_back(e);
   endtask

   // Drive one edge's inputs; expected outputs after that edge go to the scoreboard.
   task automatic step(input logic [2:0] a, input logic [2:0] b, input logic m,
                       input logic clr, input logic [2:0] ela, input logic [2:0] elb,
                       input logic ef, input logic [1:0] ec, input string nm);
      a_in = a; b_in = b; modo = m; fault_clr = clr;
      @(posedge clk);
      #1;
      push(ela, elb, ef, ec, nm);
   endtask

   // Monitor: outputs are valid every cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (lamp_a !== e.la || lamp_b !== e.lb || fault !== e.f || fault_code !== e.c) begin
            errors++;
            $display("FAIL %s: got lamp_a=%b lamp_b=%b fault=%b code=%0d, expected lamp_a=%b lamp_b=%b fault=%b code=%0d",
                     e.nm, lamp_a, lamp_b, fault, fault_code, e.la, e.lb, e.f, e.c);
         end
      end
   end

   logic [2:0] seq_a[9];
   logic [2:0] seq_b[9];

   initial begin
      seq_a = '{GRN, GRN, GRN, GRN, YEL, RED, RED, RED, RED};
      seq_b = '{RED, RED, RED, RED, RED, GRN, GRN, GRN, YEL};
      reset = 1'b0; modo = 1'b0; fault_clr = 1'b0; a_in = RED; b_in = RED;
      #1 push(RED, RED, 1'b0, 2'd0, "reset_state");
      @(negedge clk); #1 reset = 1'b1;

      // normal cycle twice
      repeat (2)
         for (int i = 0; i < 9; i++)
            step(seq_a[i], seq_b[i], 0, 0, seq_a[i], seq_b[i], 0, 2'd0, "normal");

      // conflict -> fault, flash red 2 on / 2 off
      step(GRN, RED, 0, 0, GRN, RED, 0, 2'd0, "pre_conflict");
      step(GRN, GRN, 0, 0, RED, RED, 1, 2'd2, "conflict_entry");
      step(GRN, GRN, 0, 0, RED, RED, 1, 2'd2, "fault_on2");
      step(GRN, GRN, 0, 0, OFF, OFF, 1, 2'd2, "fault_off1");
      step(GRN, GRN, 0, 0, OFF, OFF, 1, 2'd2, "fault_off2");
      step(GRN, GRN, 0, 0, RED, RED, 1, 2'd2, "fault_on_again");
      step(RED, GRN, 0, 1, RED, RED, 1, 2'd2, "clr_wrong_inputs");
      step(GRN, RED, 0, 1, GRN, RED, 0, 2'd0, "clr_ok");

      // illegal transition, then one-hot beats conflict
      step(RED, RED, 0, 0, RED, RED, 1, 2'd3, "illegal_seq");
      step(GRN, RED, 0, 1, GRN, RED, 0, 2'd0, "clr_after_seq");
      step(3'b011, GRN, 0, 0, RED, RED, 1, 2'd1, "not_onehot_prio");
      step(3'b011, GRN, 0, 0, RED, RED, 1, 2'd1, "not_onehot_hold");
      step(GRN, RED, 0, 1, GRN, RED, 0, 2'd0, "clr_after_onehot");

      // night mode; checks suspended while in it
      step(GRN, RED, 1, 0, YEL, YEL, 0, 2'd0, "night_entry");
      step(YEL, YEL, 1, 0, YEL, YEL, 0, 2'd0, "night_on2");
      step(YEL, YEL, 1, 0, OFF, OFF, 0, 2'd0, "night_off1");
      step(3'b111, GRN, 1, 0, OFF, OFF, 0, 2'd0, "night_off2");
      step(YEL, YEL, 1, 0, YEL, YEL, 0, 2'd0, "night_on_again");
      step(RED, GRN, 0, 0, RED, GRN, 0, 2'd0, "night_exit_noseq");

      // fault wins over modo; modo ignored in fault
      step(GRN, GRN, 1, 0, RED, RED, 1, 2'd2, "fault_over_modo");
      step(GRN, GRN, 1, 0, RED, RED, 1, 2'd2, "fault_ignores_modo");
      step(GRN, GRN, 1, 0, OFF, OFF, 1, 2'd2, "fault_off_modo");

      // one unchecked edge, then async reset between edges
      @(negedge clk); @(posedge clk); #1;
      reset = 1'b0;
      #1 push(RED, RED, 1'b0, 2'd0, "async_reset");
      @(negedge clk); #1 reset = 1'b1;

      // after reset prev = RED/RED; night exit straight into fault
      step(GRN, RED, 0, 0, GRN, RED, 0, 2'd0, "post_reset");
      step(GRN, RED, 1, 0, YEL, YEL, 0, 2'd0, "night_entry2");
      step(GRN, GRN, 0, 0, RED, RED, 1, 2'd2, "night_to_fault");
      step(GRN, RED, 0, 1, GRN, RED, 0, 2'd0, "clr_final");

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
